// File: rtl/add_round_key_stage.sv
// Registered AES AddRoundKey stage: local round-key store loaded word by word,
// XOR of each accepted state with its round key, output register plus one-entry skid.
module add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_clear,
    input  logic         key_wr_en,
    input  logic [31:0]  key_wr_word,
    output logic         keys_ready,
    output logic         key_wr_err,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [3:0]   in_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [3:0]   out_round,
    output logic         out_last,
    output logic         out_err
);
    localparam int WORDS = 4 * (NR + 1);
    localparam int CW    = $clog2(WORDS);
    localparam int RW    = CW - 2;
    localparam logic [CW-1:0] LAST_WORD  = CW'(WORDS - 1);
    localparam logic [3:0]    LAST_ROUND = 4'(NR);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    logic [1:0]    key_state;
    logic [CW-1:0] word_cnt;
    logic [127:0]  key_mem [0:NR];
    logic          key_wr_fire;

    assign key_wr_fire = key_wr_en && !key_clear && (key_state != S_READY);
    assign keys_ready  = (key_state == S_READY);

    always_ff @(posedge clk) begin
        if (rst) begin
            key_state  <= S_EMPTY;
            word_cnt   <= '0;
            key_wr_err <= 1'b0;
        end else begin
            key_wr_err <= key_wr_en && !key_clear && (key_state == S_READY);
            if (key_clear) begin
                key_state <= S_EMPTY;
                word_cnt  <= '0;
            end else if (key_wr_fire) begin
                word_cnt  <= word_cnt + 1'b1;
                key_state <= (word_cnt == LAST_WORD) ? S_READY : S_LOAD;
            end
        end
    end

    // Word k of a round key lands in bits [127-32k -: 32], so the offset is (3-k)*32.
    always_ff @(posedge clk) begin
        if (key_wr_fire)
            key_mem[word_cnt[CW-1:2]][{~word_cnt[1:0], 5'b0} +: 32] <= key_wr_word;
    end

    logic          skid_full;
    logic [127:0]  skid_state;
    logic [3:0]    skid_round;
    logic          skid_last;
    logic          skid_err;

    logic          accept;
    logic          new_err;
    logic          new_last;
    logic [RW-1:0] rd_idx;
    logic [127:0]  new_state;

    assign in_ready  = keys_ready && !skid_full;
    assign accept    = in_valid && in_ready;
    assign new_err   = (in_round > LAST_ROUND);
    assign new_last  = (in_round == LAST_ROUND);
    assign rd_idx    = new_err ? '0 : RW'(in_round);
    assign new_state = new_err ? in_state : (in_state ^ key_mem[rd_idx]);

    // The skid always drains ahead of a fresh beat; in_ready is low while it is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_state  <= '0;
            out_round  <= '0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
            skid_full  <= 1'b0;
            skid_state <= '0;
            skid_round <= '0;
            skid_last  <= 1'b0;
            skid_err   <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_full) begin
                out_valid <= 1'b1;
                out_state <= skid_state;
                out_round <= skid_round;
                out_last  <= skid_last;
                out_err   <= skid_err;
                skid_full <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_state <= new_state;
                out_round <= in_round;
                out_last  <= new_last;
                out_err   <= new_err;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_full  <= 1'b1;
            skid_state <= new_state;
            skid_round <= in_round;
            skid_last  <= new_last;
            skid_err   <= new_err;
        end
    end
endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage: key load, XOR results, handshake stalls,
// key clear, out-of-range rounds and reset with data in flight.
module tb_add_round_key_stage;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_clear = 1'b0;
    logic         key_wr_en = 1'b0;
    logic [31:0]  key_wr_word = '0;
    logic         keys_ready;
    logic         key_wr_err;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic [3:0]   in_round = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;
    logic         out_err;

    int tests_run = 0;
    int tests_failed = 0;

    add_round_key_stage #(.NR(10)) dut (
        .clk(clk), .rst(rst), .key_clear(key_clear), .key_wr_en(key_wr_en),
        .key_wr_word(key_wr_word), .keys_ready(keys_ready), .key_wr_err(key_wr_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_round(in_round),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_round(out_round), .out_last(out_last), .out_err(out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, run %0d failed %0d", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    // Key words: FIPS-197 cipher key first, then an arbitrary directed pattern.
    function automatic logic [31:0] kw(input int i);
        logic [7:0] b;
        b = 8'(i);
        case (i)
            0:       return 32'h00010203;
            1:       return 32'h04050607;
            2:       return 32'h08090a0b;
            3:       return 32'h0c0d0e0f;
            default: return {b, b * 8'd7, b ^ 8'h5a, ~b};
        endcase
    endfunction

    function automatic logic [127:0] rk(input int r);
        return {kw(4*r), kw(4*r+1), kw(4*r+2), kw(4*r+3)};
    endfunction

    function automatic logic [127:0] st(input int r);
        logic [7:0] b;
        b = 8'(r);
        return {16{b}} ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({keys_ready, key_wr_err, in_ready, out_valid, out_state, out_round, out_last, out_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ready=%b werr=%b in_ready=%b ov=%b os=%h or=%h ol=%b oe=%b, all zero required",
                     keys_ready, key_wr_err, in_ready, out_valid, out_state, out_round, out_last, out_err);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({keys_ready, in_ready, out_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got ready=%b in_ready=%b ov=%b, 000 required", keys_ready, in_ready, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic load_keys();
        for (int i = 0; i < 44; i++) begin
            key_wr_en = 1'b1;
            key_wr_word = kw(i);
            tick();
            if (i == 42) begin
                tests_run++;
                if (keys_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL keys_ready_early: got %b after word 42, 0 required", keys_ready);
                end
            end
        end
        key_wr_en = 1'b0;
        tests_run++;
        if (keys_ready !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL keys_ready_rise: got ready=%b in_ready=%b after word 43, 1/1 required", keys_ready, in_ready);
        end
    endtask

    task automatic test_first_xor();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_state = 128'h00112233445566778899aabbccddeeff;
        in_round = 4'd0;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, out_state, out_round, out_last, out_err} !==
            {1'b1, 128'h00102030405060708090a0b0c0d0e0f0, 4'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL fips_round0: got ov=%b os=%h or=%h ol=%b oe=%b, os=00102030405060708090a0b0c0d0e0f0 required",
                     out_valid, out_state, out_round, out_last, out_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int r = 0; r <= 10; r++) begin
            in_valid = 1'b1;
            in_state = st(r);
            in_round = 4'(r);
            tick();
            tests_run++;
            if ({out_valid, out_state, out_round, out_last, out_err} !==
                {1'b1, st(r) ^ rk(r), 4'(r), (r == 10), 1'b0}) begin
                tests_failed++;
                $display("FAIL b2b_round%0d: got ov=%b os=%h or=%h ol=%b oe=%b, os=%h required",
                         r, out_valid, out_state, out_round, out_last, out_err, st(r) ^ rk(r));
            end
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got out_valid=%b, 0 required", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [127:0] exp_a, exp_b, exp_c;
        exp_a = st(1) ^ rk(1);
        exp_b = st(2) ^ rk(2);
        exp_c = st(3) ^ rk(3);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_state = st(1); in_round = 4'd1;
        tick();
        tests_run++;
        if ({out_valid, out_state, in_ready} !== {1'b1, exp_a, 1'b1}) begin
            tests_failed++;
            $display("FAIL stall_first: got ov=%b os=%h in_ready=%b, os=%h in_ready=1 required", out_valid, out_state, in_ready, exp_a);
        end
        in_state = st(2); in_round = 4'd2;
        tick();
        in_state = st(3); in_round = 4'd3;
        for (int c = 0; c < 2; c++) begin
            tests_run++;
            if ({out_valid, out_state, out_round, in_ready} !== {1'b1, exp_a, 4'd1, 1'b0}) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got ov=%b os=%h or=%h in_ready=%b, os=%h in_ready=0 required",
                         c, out_valid, out_state, out_round, in_ready, exp_a);
            end
            if (c == 0) tick();
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if ({out_valid, out_state, out_round, in_ready} !== {1'b1, exp_b, 4'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL stall_drain_skid: got ov=%b os=%h or=%h in_ready=%b, os=%h or=2 required",
                     out_valid, out_state, out_round, in_ready, exp_b);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, out_state, out_round} !== {1'b1, exp_c, 4'd3}) begin
            tests_failed++;
            $display("FAIL stall_third: got ov=%b os=%h or=%h, os=%h or=3 required", out_valid, out_state, out_round, exp_c);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_no_dup: got out_valid=%b, 0 required", out_valid);
        end
    endtask

    task automatic test_err();
        int rounds [3] = '{11, 12, 15};
        out_ready = 1'b1;
        foreach (rounds[i]) begin
            in_valid = 1'b1;
            in_state = st(rounds[i]);
            in_round = 4'(rounds[i]);
            tick();
            tests_run++;
            if ({out_valid, out_state, out_round, out_last, out_err} !==
                {1'b1, st(rounds[i]), 4'(rounds[i]), 1'b0, 1'b1}) begin
                tests_failed++;
                $display("FAIL err_round%0d: got ov=%b os=%h ol=%b oe=%b, os=%h oe=1 required",
                         rounds[i], out_valid, out_state, out_last, out_err, st(rounds[i]));
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_key_err();
        key_wr_en = 1'b1;
        key_wr_word = 32'hffffffff;
        tick();
        key_wr_en = 1'b0;
        tests_run++;
        if ({key_wr_err, keys_ready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL key_wr_err_pulse: got werr=%b ready=%b, 1/1 required", key_wr_err, keys_ready);
        end
        tick();
        tests_run++;
        if (key_wr_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL key_wr_err_clear: got %b, 0 required", key_wr_err);
        end
        for (int r = 0; r <= 10; r += 5) begin
            in_valid = 1'b1;
            in_state = st(r + 20);
            in_round = 4'(r);
            tick();
            tests_run++;
            if ({out_valid, out_state, out_last} !== {1'b1, st(r + 20) ^ rk(r), (r == 10)}) begin
                tests_failed++;
                $display("FAIL keys_unchanged_r%0d: got ov=%b os=%h ol=%b, os=%h required",
                         r, out_valid, out_state, out_last, st(r + 20) ^ rk(r));
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_clear_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_state = st(3); in_round = 4'd3;
        tick();
        key_clear = 1'b1;
        in_state = st(4); in_round = 4'd4;
        tick();
        key_clear = 1'b0;
        in_state = st(6); in_round = 4'd6;
        tests_run++;
        if ({keys_ready, in_ready, out_valid, out_state} !== {1'b0, 1'b0, 1'b1, st(3) ^ rk(3)}) begin
            tests_failed++;
            $display("FAIL clear_blocks: got ready=%b in_ready=%b ov=%b os=%h, 0/0/1 os=%h required",
                     keys_ready, in_ready, out_valid, out_state, st(3) ^ rk(3));
        end
        tick();
        out_ready = 1'b1;
        tick();
        tests_run++;
        if ({out_valid, out_state, out_round} !== {1'b1, st(4) ^ rk(4), 4'd4}) begin
            tests_failed++;
            $display("FAIL clear_pending: got ov=%b os=%h or=%h, os=%h or=4 required", out_valid, out_state, out_round, st(4) ^ rk(4));
        end
        tick();
        tests_run++;
        if ({out_valid, in_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL clear_no_accept: got ov=%b in_ready=%b, 00 required", out_valid, in_ready);
        end
        in_valid = 1'b0;
        key_clear = 1'b1;
        key_wr_en = 1'b1;
        key_wr_word = 32'hdeadbeef;
        tick();
        key_clear = 1'b0;
        key_wr_en = 1'b0;
        load_keys();
        in_valid = 1'b1;
        in_state = st(7); in_round = 4'd7;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, out_state} !== {1'b1, st(7) ^ rk(7)}) begin
            tests_failed++;
            $display("FAIL reload_xor: got ov=%b os=%h, os=%h required", out_valid, out_state, st(7) ^ rk(7));
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_state = st(8); in_round = 4'd8;
        tick();
        in_state = st(9); in_round = 4'd9;
        tick();
        tests_run++;
        if ({out_valid, in_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rst_setup: got ov=%b in_ready=%b, 10 required", out_valid, in_ready);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({keys_ready, key_wr_err, in_ready, out_valid, out_state, out_round, out_last, out_err} !== '0) begin
            tests_failed++;
            $display("FAIL rst_midstream: got ready=%b in_ready=%b ov=%b os=%h or=%h, all zero required",
                     keys_ready, in_ready, out_valid, out_state, out_round);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if ({in_ready, out_valid} !== 2'b00) begin
                tests_failed++;
                $display("FAIL rst_no_reload%0d: got in_ready=%b ov=%b, 00 required", c, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        load_keys();
        test_first_xor();
        test_back_to_back();
        test_stall();
        test_err();
        test_key_err();
        test_clear_midstream();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
- Registered AddRoundKey stage sitting directly downstream of the combinational mixColumns block in the AES-128 round datapath.
- Holds the full expanded key schedule in a local round-key store, loaded one 32-bit word at a time from the key expansion logic.
- XORs each incoming 128-bit state with the round key selected by its round index and emits the result through a valid/ready handshake.
- Also serves round 0 (initial whitening) and the final round, where mixColumns is bypassed upstream.

Parameters:
- NR, 10, number of AES rounds; store holds NR+1 round keys, i.e. 4*(NR+1) words.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- key_clear  input  1  discard stored schedule, return to EMPTY
- key_wr_en  input  1  key word write strobe
- key_wr_word  input  32  key word; written in order w0,w1,...,w[4*NR+3]
- keys_ready  output  1  full schedule loaded
- key_wr_err  output  1  one-cycle pulse: write attempted while READY
- in_valid  input  1  state word valid (from mixColumns path)
- in_ready  output  1  stage can accept
- in_state  input  128  state in, byte 0 = [127:120]
- in_round  input  4  round index 0..NR
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_state  output  128  in_state XOR roundkey[in_round]
- out_round  output  4  in_round passed along
- out_last  output  1  out_round == NR
- out_err  output  1  in_round > NR; out_state = in_state unmodified

Behaviour:
- Key store: NR+1 entries x 128 bits. Word w[4r+k] maps to roundkey[r] bits [127-32k -: 32].
- Key FSM states: EMPTY, LOAD, READY.
  - EMPTY: key_wr_en writes w0, word counter := 1, go to LOAD.
  - LOAD: each key_wr_en writes w[counter], counter++. The write of word 4*NR+3 moves to READY in the same cycle; keys_ready = 1 from the next cycle.
  - READY: key_wr_en is ignored and key_wr_err pulses for 1 cycle. Stored keys are unchanged.
  - key_clear (any state): go to EMPTY, counter := 0, keys_ready := 0. If key_clear and key_wr_en are asserted together, key_clear wins and the word is dropped.
- Handshake:
  - in_ready = keys_ready AND (NOT skid_full).
  - Transfer occurs when in_valid AND in_ready. out_valid/out_state must not change while out_valid=1 and out_ready=0.
- Pipeline:
  - Output register plus a one-entry skid buffer, giving 1-cycle latency (accept at edge N, out_valid at N+1).
  - Sustains 1 transfer/cycle while out_ready=1.
  - When out_ready drops, at most one further accepted beat goes to the skid; in_ready then drops combinationally from registered skid_full.
  - The skid drains to the output register first, preserving order.
- Arithmetic: pure 128-bit XOR; key read uses in_round at accept time.
- out_err: in_round > NR (values NR+1..15) is still accepted, passed through unXORed with out_err=1. No entry is dropped.
- key_clear with data in flight: the output and skid contents (already XORed) are retained and drain normally. New accepts are blocked until READY again.
- Reset: FSM=EMPTY, counter=0, key store contents don't-care. All outputs at reset:
  - keys_ready=0, key_wr_err=0, in_ready=0
  - out_valid=0, out_state=0, out_round=0, out_last=0, out_err=0
  - skid empty
- Reset asserted mid-transfer drops all buffered data; no out_valid the cycle after.

Test Plan:
- FIPS-197 key 000102030405060708090a0b0c0d0e0f loaded as words 00010203,04050607,08090a0b,0c0d0e0f (+ 40 further words) -> keys_ready rises one cycle after word 43. Then in_state=00112233445566778899aabbccddeeff, in_round=0 -> next cycle out_state=00102030405060708090a0b0c0d0e0f0, out_last=0, out_err=0.
- Back-to-back rounds 0..10 with out_ready=1 -> 11 outputs on 11 consecutive cycles, in order. Only the round-10 output has out_last=1; each out_state equals the XOR with the matching loaded key.
- out_ready held low 3 cycles while in_valid stays high -> exactly 2 beats buffered, in_ready=0. out_state stable; on release both drain in order with no loss or duplication.
- in_round=12 -> out_err=1 and out_state == in_state.
- Extra key_wr_en after load -> key_wr_err 1-cycle pulse, subsequent XOR results unchanged. key_clear mid-stream -> keys_ready=0, in_ready=0 next cycle, pending output still delivered.
- rst asserted while out_valid=1 and skid full -> next cycle all outputs 0. Before reload, in_ready stays 0 despite in_valid=1.
